// File: rtl/trace_pkg.sv
// Shared definitions for the retirement-trace unit: event kinds, entry layout
// and the width helper used to size flat storage words.
package trace_pkg;

    localparam logic [1:0] KIND_RETIRE = 2'd0;
    localparam logic [1:0] KIND_REG    = 2'd1;
    localparam logic [1:0] KIND_STORE  = 2'd2;
    localparam logic [1:0] KIND_HALT   = 2'd3;

    localparam int TP_ADDR_W = 16;
    localparam int TP_DATA_W = 16;
    localparam int TP_CNT_W  = 32;

    // Field order matches the flat word packed by the top (inum in the MSBs).
    typedef struct packed {
        logic [TP_CNT_W-1:0]  inum;
        logic [1:0]           kind;
        logic [TP_ADDR_W-1:0] pc;
        logic [3:0]           reg_idx;
        logic [TP_DATA_W-1:0] value;
        logic [TP_ADDR_W-1:0] addr;
    } trace_entry_t;

    function automatic int entry_width(input int addr_w, input int data_w, input int cnt_w);
        return cnt_w + 2 + addr_w + 4 + data_w + addr_w;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace storage with first-word fall-through head, optional
// overwrite-oldest when full, and a per-cycle "entry lost" indication.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WRAP  = 0,
    parameter int W     = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   wr_en_i,
    input  logic [W-1:0]           wr_data_i,
    input  logic                   rd_ready_i,
    output logic                   rd_valid_o,
    output logic [W-1:0]           rd_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   lost_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          empty_s, full_s, pop_s, push_s, over_s, lost_s;

    // Push/pop/overwrite decisions and next-state pointers and occupancy.
    always_comb begin
        empty_s = (count_q == '0);
        full_s  = (count_q == CNT_FULL);
        pop_s   = rd_ready_i && !empty_s;
        push_s  = 1'b0;
        over_s  = 1'b0;
        lost_s  = 1'b0;
        if (wr_en_i) begin
            if (!full_s || pop_s) begin
                push_s = 1'b1;
            end else if (WRAP != 0) begin
                push_s = 1'b1;
                over_s = 1'b1;
                lost_s = 1'b1;
            end else begin
                lost_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
        wr_ptr_d = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
        rd_ptr_d = (pop_s || over_s) ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
        if (push_s && !pop_s && !over_s) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_ONE;
        end else begin
            count_d = count_q;
        end
    end

    // Pointer and occupancy registers; clear flushes the buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the head is forced to zero whenever the buffer is empty.
    always_ff @(posedge clk) begin
        if (push_s && !clear_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_valid_o = !empty_s;
    assign rd_data_o  = empty_s ? '0 : mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign lost_o     = lost_s;

endmodule

// File: rtl/retire_trace_buffer.sv
// Retirement-trace capture: counters, accept/enable gating, sticky flags and
// the cycle watchdog around a circular FWFT trace store.
module retire_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 32,
    parameter int MAX_CYCLES = 100000,
    parameter int WRAP       = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   ret_valid,
    input  logic [1:0]             ret_kind,
    input  logic [ADDR_W-1:0]      ret_pc,
    input  logic [3:0]             ret_reg,
    input  logic [DATA_W-1:0]      ret_value,
    input  logic [ADDR_W-1:0]      ret_addr,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [CNT_W-1:0]       rd_inum,
    output logic [1:0]             rd_kind,
    output logic [ADDR_W-1:0]      rd_pc,
    output logic [3:0]             rd_reg,
    output logic [DATA_W-1:0]      rd_value,
    output logic [ADDR_W-1:0]      rd_addr,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   halted,
    output logic                   timeout,
    output logic [CNT_W-1:0]       cycle_count,
    output logic [CNT_W-1:0]       inst_count
);

    localparam int EW = entry_width(ADDR_W, DATA_W, CNT_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] WDOG_LIM = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] cycle_q, cycle_d, inst_q, inst_d;
    logic             halted_q, halted_d, timeout_q, timeout_d, overflow_q, overflow_d;
    logic             frozen_s, accept_s, store_s, lost_s;
    logic [EW-1:0]    wr_data_s, rd_data_s;

    assign frozen_s  = halted_q | timeout_q;
    assign accept_s  = ret_valid & !frozen_s;
    assign store_s   = accept_s & enable;
    // inum is the instruction number before this event is counted.
    assign wr_data_s = {inst_q, ret_kind, ret_pc, ret_reg, ret_value, ret_addr};

    trace_fifo #(
        .DEPTH (DEPTH),
        .WRAP  (WRAP),
        .W     (EW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .wr_en_i    (store_s),
        .wr_data_i  (wr_data_s),
        .rd_ready_i (rd_ready),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_data_s),
        .count_o    (count),
        .lost_o     (lost_s)
    );

    // Counter, watchdog and sticky-flag next state.
    always_comb begin
        cycle_d    = cycle_q;
        inst_d     = inst_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;
        overflow_d = overflow_q | lost_s;
        if (!frozen_s) begin
            cycle_d = cycle_q + CNT_ONE;
            if ((MAX_CYCLES != 0) && (cycle_q == WDOG_LIM)) begin
                timeout_d = 1'b1;
            end else begin
                timeout_d = timeout_q;
            end
        end else begin
            cycle_d = cycle_q;
        end
        if (accept_s) begin
            inst_d = inst_q + CNT_ONE;
            if (ret_kind == KIND_HALT) begin
                halted_d = 1'b1;
            end else begin
                halted_d = halted_q;
            end
        end else begin
            inst_d = inst_q;
        end
    end

    // Counter and flag registers; clear has priority over all updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q    <= '0;
            inst_q     <= '0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else if (clear) begin
            cycle_q    <= '0;
            inst_q     <= '0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            cycle_q    <= cycle_d;
            inst_q     <= inst_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign {rd_inum, rd_kind, rd_pc, rd_reg, rd_value, rd_addr} = rd_data_s;
    assign overflow    = overflow_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign cycle_count = cycle_q;
    assign inst_count  = inst_q;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Three DEPTH=4 instances share one stimulus stream (stop-when-full, wrap,
// and a 10-cycle watchdog) and are compared every cycle with a queue model.
module tb_retire_trace_buffer;

    typedef struct packed {
        logic [31:0] inum;
        logic [1:0]  kind;
        logic [15:0] pc;
        logic [3:0]  rg;
        logic [15:0] val;
        logic [15:0] addr;
    } tent_t;

    localparam int NI = 3;
    localparam int MDEPTH = 4;
    localparam int WRAPS [NI] = '{0, 1, 0};
    localparam int MAXC  [NI] = '{0, 0, 10};

    logic        clk, rst_n, clear, enable, ret_valid, rd_ready;
    logic [1:0]  ret_kind;
    logic [15:0] ret_pc, ret_value, ret_addr;
    logic [3:0]  ret_reg;

    logic        rdv [NI];
    logic [31:0] rdi [NI];
    logic [1:0]  rdk [NI];
    logic [15:0] rdp [NI];
    logic [3:0]  rdr [NI];
    logic [15:0] rdd [NI];
    logic [15:0] rda [NI];
    logic [2:0]  cnt [NI];
    logic        ovf [NI];
    logic        hlt [NI];
    logic        tmo [NI];
    logic [31:0] cyc [NI];
    logic [31:0] ins [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        retire_trace_buffer #(
            .DEPTH(4), .ADDR_W(16), .DATA_W(16), .CNT_W(32),
            .MAX_CYCLES(MAXC[g]), .WRAP(WRAPS[g])
        ) u_dut (
            .clk(clk), .rst_n(rst_n), .clear(clear), .enable(enable),
            .ret_valid(ret_valid), .ret_kind(ret_kind), .ret_pc(ret_pc),
            .ret_reg(ret_reg), .ret_value(ret_value), .ret_addr(ret_addr),
            .rd_valid(rdv[g]), .rd_ready(rd_ready), .rd_inum(rdi[g]),
            .rd_kind(rdk[g]), .rd_pc(rdp[g]), .rd_reg(rdr[g]),
            .rd_value(rdd[g]), .rd_addr(rda[g]), .count(cnt[g]),
            .overflow(ovf[g]), .halted(hlt[g]), .timeout(tmo[g]),
            .cycle_count(cyc[g]), .inst_count(ins[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    // Reference model state
    tent_t q0[$], q1[$], q2[$];
    int    mcyc [NI];
    int    minst [NI];
    bit    mhalt [NI], mto [NI], movf [NI];
    int    pq0[$], pq1[$];

    function automatic int qsz(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic void qpop(input int i);
        case (i)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void qpush(input int i, input tent_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endfunction

    function automatic tent_t qhead(input int i);
        case (i)
            0: return q0[0];
            1: return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void mreset(input int i);
        while (qsz(i) > 0) qpop(i);
        mcyc[i] = 0; minst[i] = 0;
        mhalt[i] = 1'b0; mto[i] = 1'b0; movf[i] = 1'b0;
    endfunction

    function automatic void mstep(input int i);
        bit frozen, acc;
        tent_t e;
        if (clear) begin
            mreset(i);
            return;
        end
        frozen = mhalt[i] || mto[i];
        acc = ret_valid && !frozen;
        if (qsz(i) > 0 && rd_ready) qpop(i);
        if (acc && enable) begin
            e = '{inum: minst[i], kind: ret_kind, pc: ret_pc, rg: ret_reg,
                  val: ret_value, addr: ret_addr};
            if (qsz(i) < MDEPTH) begin
                qpush(i, e);
            end else begin
                movf[i] = 1'b1;
                if (WRAPS[i] != 0) begin
                    qpop(i);
                    qpush(i, e);
                end
            end
        end
        if (acc) begin
            minst[i]++;
            if (ret_kind == 2'd3) mhalt[i] = 1'b1;
        end
        if (!frozen) begin
            if (MAXC[i] != 0 && mcyc[i] == MAXC[i] - 1) mto[i] = 1'b1;
            mcyc[i]++;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input int i);
        tent_t h;
        chk($sformatf("u%0d.rd_valid", i), 64'(rdv[i]), 64'(qsz(i) > 0));
        chk($sformatf("u%0d.count", i), 64'(cnt[i]), 64'(qsz(i)));
        chk($sformatf("u%0d.overflow", i), 64'(ovf[i]), 64'(movf[i]));
        chk($sformatf("u%0d.halted", i), 64'(hlt[i]), 64'(mhalt[i]));
        chk($sformatf("u%0d.timeout", i), 64'(tmo[i]), 64'(mto[i]));
        chk($sformatf("u%0d.cycle_count", i), 64'(cyc[i]), 64'(32'(mcyc[i])));
        chk($sformatf("u%0d.inst_count", i), 64'(ins[i]), 64'(32'(minst[i])));
        if (qsz(i) > 0) begin
            h = qhead(i);
            chk($sformatf("u%0d.rd_inum", i), 64'(rdi[i]), 64'(h.inum));
            chk($sformatf("u%0d.rd_fields", i), 64'({rdk[i], rdp[i], rdr[i], rdd[i], rda[i]}),
                64'({h.kind, h.pc, h.rg, h.val, h.addr}));
        end
    endtask

    task automatic step();
        if (rdv[0] && rd_ready) pq0.push_back(int'(rdi[0]));
        if (rdv[1] && rd_ready) pq1.push_back(int'(rdi[1]));
        for (int i = 0; i < NI; i++) mstep(i);
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) check_all(i);
    endtask

    task automatic ev(input logic [1:0] k, input logic [15:0] pc, input logic [3:0] rg,
                      input logic [15:0] v, input logic [15:0] a);
        ret_valid = 1'b1; ret_kind = k; ret_pc = pc; ret_reg = rg; ret_value = v; ret_addr = a;
        step();
        ret_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        ret_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int hold;
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1; ret_valid = 1'b0; rd_ready = 1'b0;
        ret_kind = 2'd0; ret_pc = 16'd0; ret_reg = 4'd0; ret_value = 16'd0; ret_addr = 16'd0;
        for (int i = 0; i < NI; i++) mreset(i);
        #2;
        for (int i = 0; i < NI; i++) check_all(i);
        chk("reset.rd_head", 64'({rdi[0], rdk[0], rdp[0], rdr[0], rdd[0], rda[0]}), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Watchdog: 10-cycle instance times out and stops capturing
        idle(12);
        chk("wdog.timeout", 64'(tmo[2]), 64'd1);
        chk("wdog.cycle_count", 64'(cyc[2]), 64'd10);
        chk("wdog.other_timeout", 64'(tmo[0]), 64'd0);
        ev(2'd1, 16'h0020, 4'd1, 16'h1234, 16'h0000);
        chk("wdog.ignored_count", 64'(cnt[2]), 64'd0);
        chk("wdog.ignored_inst", 64'(ins[2]), 64'd0);
        do_clear();
        for (int i = 0; i < NI; i++) begin
            chk("clear.state", 64'({cnt[i], ovf[i], hlt[i], tmo[i]}), 64'd0);
            chk("clear.counters", 64'({cyc[i], ins[i]}), 64'd0);
        end

        // Drain order with consumer always ready
        rd_ready = 1'b1;
        pq0.delete();
        ev(2'd1, 16'h0000, 4'd3, 16'h0005, 16'h0000);
        ev(2'd2, 16'h0002, 4'd0, 16'h0005, 16'h0010);
        ev(2'd0, 16'h0004, 4'd0, 16'h0000, 16'h0000);
        idle(3);
        chk("drain.npop", 64'(pq0.size()), 64'd3);
        for (int k = 0; k < 3 && k < pq0.size(); k++) chk("drain.inum", 64'(pq0[k]), 64'(k));
        chk("drain.count", 64'(cnt[0]), 64'd0);
        chk("drain.inst", 64'(ins[0]), 64'd3);

        // Full: stop-when-full vs overwrite-oldest
        do_clear();
        rd_ready = 1'b0;
        for (int k = 0; k < 6; k++) ev(2'd0, 16'(2 * k), 4'd0, 16'd0, 16'd0);
        chk("full0.count", 64'(cnt[0]), 64'd4);
        chk("full0.overflow", 64'(ovf[0]), 64'd1);
        chk("full0.inst", 64'(ins[0]), 64'd6);
        chk("wrap.count", 64'(cnt[1]), 64'd4);
        chk("wrap.overflow", 64'(ovf[1]), 64'd1);
        pq0.delete(); pq1.delete();
        rd_ready = 1'b1;
        idle(5);
        rd_ready = 1'b0;
        chk("full0.npop", 64'(pq0.size()), 64'd4);
        chk("wrap.npop", 64'(pq1.size()), 64'd4);
        for (int k = 0; k < 4 && k < pq0.size(); k++) chk("full0.inum", 64'(pq0[k]), 64'(k));
        for (int k = 0; k < 4 && k < pq1.size(); k++) chk("wrap.inum", 64'(pq1[k]), 64'(k + 2));

        // Full with simultaneous push and pop
        do_clear();
        for (int k = 0; k < 4; k++) ev(2'd0, 16'(k), 4'd0, 16'd0, 16'd0);
        rd_ready = 1'b1;
        ev(2'd0, 16'h0040, 4'd0, 16'd0, 16'd0);
        rd_ready = 1'b0;
        chk("pushpop.count", 64'(cnt[0]), 64'd4);
        chk("pushpop.overflow", 64'(ovf[0]), 64'd0);
        chk("pushpop.head", 64'(rdi[0]), 64'd1);

        // Halt freezes capture and counters
        do_clear();
        ev(2'd0, 16'h0008, 4'd0, 16'd0, 16'd0);
        ev(2'd3, 16'h000A, 4'd0, 16'd0, 16'd0);
        ev(2'd1, 16'h000C, 4'd2, 16'h0007, 16'd0);
        ev(2'd1, 16'h000E, 4'd2, 16'h0008, 16'd0);
        chk("halt.halted", 64'(hlt[0]), 64'd1);
        chk("halt.count", 64'(cnt[0]), 64'd2);
        chk("halt.inst", 64'(ins[0]), 64'd2);
        hold = int'(cyc[0]);
        idle(3);
        chk("halt.cycle_hold", 64'(cyc[0]), 64'(32'(hold)));
        rd_ready = 1'b1;
        idle(1);
        rd_ready = 1'b0;
        chk("halt.last_kind", 64'(rdk[0]), 64'd3);
        chk("halt.last_pc", 64'(rdp[0]), 64'h000A);

        // Randomized traffic against the model
        do_clear();
        for (int n = 0; n < 400; n++) begin
            clear     = ($urandom_range(0, 49) == 0);
            ret_valid = ($urandom_range(0, 2) != 0);
            enable    = ($urandom_range(0, 3) != 0);
            rd_ready  = $urandom_range(0, 1) != 0;
            ret_kind  = 2'($urandom_range(0, 2));
            ret_pc    = 16'($urandom);
            ret_reg   = 4'($urandom);
            ret_value = 16'($urandom);
            ret_addr  = 16'($urandom);
            step();
        end
        clear = 1'b0;
        ret_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
